// File: rtl/multicore_pkg.sv
// Shared definitions for the fetch/decode slice: line geometry, the
// canonical NOOP, RISC-V major opcodes and the streamer state encoding.
package multicore_pkg;

   localparam int WORDS_PER_LINE = 8;
   localparam int INST_SIZE      = 32;
   localparam int WORD_BITS      = $clog2(WORDS_PER_LINE);
   localparam int LINE_BITS      = WORDS_PER_LINE * INST_SIZE;
   localparam int LINE_SIZE      = WORDS_PER_LINE * (INST_SIZE / 8);

   // addi x0,x0,0 -- what decode sees whenever nothing valid is presented
   localparam logic [INST_SIZE-1:0] NOOP_INST = 32'h0000_0013;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_FENCE  = 7'b0001111,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_ALU    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      BRANCHES  = 7'b1100011,
      JALR      = 7'b1100111,
      JAL       = 7'b1101111,
      OP_SYSTEM = 7'b1110011
   } t_opcode;

   typedef enum logic [0:0] {
      EMPTY  = 1'b0,
      STREAM = 1'b1
   } t_stream_state;

   // Control transfers are the opcodes after which the rest of a line is dead
   function automatic logic is_ctrl_op(input t_opcode op);
      return (op == BRANCHES) || (op == JAL) || (op == JALR);
   endfunction

endpackage

// File: rtl/inst_line_streamer_if.sv
// Bundles the cache-line offer handshake and the decode-side instruction
// handshake. The streamer uses the slave view; whoever drives the cache
// side and consumes instructions uses the master view.
interface inst_line_streamer_if;
   import multicore_pkg::*;

   logic                  line_valid;
   logic                  line_ready;
   logic [LINE_BITS-1:0]  line_data;
   logic [31:0]           line_pc;
   logic [WORD_BITS-1:0]  line_start;

   logic                  inst_valid;
   logic                  inst_ready;
   logic [INST_SIZE-1:0]  inst;
   logic [31:0]           inst_pc;
   logic                  inst_is_ctrl;

   modport slave (
      input  line_valid, line_data, line_pc, line_start, inst_ready,
      output line_ready, inst_valid, inst, inst_pc, inst_is_ctrl
   );

   modport master (
      output line_valid, line_data, line_pc, line_start, inst_ready,
      input  line_ready, inst_valid, inst, inst_pc, inst_is_ctrl
   );

endinterface

// File: rtl/inst_line_streamer.sv
// Buffers one instruction-cache line and hands it to decode one word per
// cycle, starting at an arbitrary word, cutting the line short after a
// control transfer, and refilling back-to-back when the last word leaves.
module inst_line_streamer
   import multicore_pkg::*;
#(
   parameter bit STOP_ON_CTRL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   inst_line_streamer_if.slave bus
);

   localparam logic [0:0]           ST_EMPTY  = EMPTY;
   localparam logic [0:0]           ST_STREAM = STREAM;
   localparam logic [WORD_BITS-1:0] LAST_IDX  = WORD_BITS'(WORDS_PER_LINE - 1);
   localparam logic [31:0]          BASE_MASK = ~(32'(LINE_SIZE) - 32'd1);

   logic [0:0]                                state;
   logic [WORD_BITS-1:0]                      idx;
   logic [31:0]                               base;
   logic [WORDS_PER_LINE-1:0][INST_SIZE-1:0]  line_buf;

   logic [INST_SIZE-1:0] cur_word;
   logic                 cur_valid;
   logic                 cur_ctrl;
   logic                 fire;
   logic                 last;
   logic                 ctrl_stop;
   logic                 ready_int;
   logic                 accept;

   // Present the selected word to decode, or the NOOP with zeroed sideband when idle
   always_comb begin
      cur_word  = line_buf[idx];
      cur_valid = (state == ST_STREAM);
      cur_ctrl  = 1'b0;
      bus.inst_valid   = 1'b0;
      bus.inst         = NOOP_INST;
      bus.inst_pc      = '0;
      bus.inst_is_ctrl = 1'b0;
      if (cur_valid) begin
         cur_ctrl         = is_ctrl_op(t_opcode'(cur_word[6:0]));
         bus.inst_valid   = 1'b1;
         bus.inst         = cur_word;
         bus.inst_pc      = base + {{(32-WORD_BITS-2){1'b0}}, idx, 2'b00};
         bus.inst_is_ctrl = cur_ctrl;
      end
   end

   // A new line may only land when the buffer is idle or its final word leaves normally
   always_comb begin
      fire      = cur_valid && bus.inst_ready;
      last      = (idx == LAST_IDX);
      ctrl_stop = STOP_ON_CTRL && cur_ctrl;
      ready_int = !rst && !flush && ((state == ST_EMPTY) || (fire && last && !ctrl_stop));
      accept    = bus.line_valid && ready_int;
      bus.line_ready = ready_int;
   end

   // Sequencing: flush beats everything, then a fresh line, then word advance or retirement
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_EMPTY;
         idx      <= '0;
         base     <= '0;
         line_buf <= '0;
      end else if (flush) begin
         state <= ST_EMPTY;
         idx   <= '0;
      end else if (accept) begin
         line_buf <= bus.line_data;
         base     <= bus.line_pc & BASE_MASK;
         idx      <= bus.line_start;
         state    <= ST_STREAM;
      end else if (fire) begin
         if (ctrl_stop || last) begin
            state <= ST_EMPTY;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_line_streamer.sv
// Directed bench for inst_line_streamer: a driver offers lines and pushes the
// words decode should receive; a monitor pops and compares on every fire.
module tb_inst_line_streamer;
   import multicore_pkg::*;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        ctrl;
   } exp_t;

   logic clk;
   logic rst;
   logic flush;

   inst_line_streamer_if bus();

   exp_t exp_q[$];
   int   checks_done = 0;
   int   fail_count  = 0;

   inst_line_streamer #(.STOP_ON_CTRL(1'b1)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Word i of line id: tagged so every issued word is unique; jal selects opcode
   function automatic logic [31:0] make_word(input int id, input int i, input logic jal);
      return {8'(id), 8'h00, 8'(i), 1'b0, (jal ? 7'b1101111 : 7'b0110011)};
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks_done++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a line to the streamer
   task automatic apply_stimulus(input int id, input logic [31:0] pc, input int start, input logic [7:0] jal_mask);
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
         bus.line_data[i*INST_SIZE +: INST_SIZE] = make_word(id, i, jal_mask[i]);
      end
      bus.line_pc    = pc;
      bus.line_start = WORD_BITS'(start);
      bus.line_valid = 1'b1;
   endtask

   // Queue the words decode is expected to receive from a line
   task automatic push_expected(input int id, input logic [31:0] base, input int first, input int lastw, input logic [7:0] jal_mask);
      exp_t e;
      for (int i = first; i <= lastw; i++) begin
         e.inst = make_word(id, i, jal_mask[i]);
         e.pc   = base + 32'(i * 4);
         e.ctrl = jal_mask[i];
         exp_q.push_back(e);
      end
   endtask

   // Monitor: every handshaked instruction must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks_done++;
               fail_count++;
               $display("[TB] FAIL unexpected_inst: got %h at pc %h, expected none", bus.inst, bus.inst_pc);
            end else begin
               e = exp_q.pop_front();
               check_output("mon_inst", bus.inst, e.inst);
               check_output("mon_pc", bus.inst_pc, e.pc);
               check_output("mon_ctrl", 32'(bus.inst_is_ctrl), 32'(e.ctrl));
            end
         end
      end
   end

   // Directed stimulus sequence
   initial begin
      rst            = 1'b1;
      flush          = 1'b0;
      bus.inst_ready = 1'b1;
      bus.line_data  = '0;
      bus.line_pc    = '0;
      bus.line_start = '0;
      bus.line_valid = 1'b0;
      apply_stimulus(9, 32'h700, 0, 8'h00);

      // Reset held two cycles with a line offered
      tick();
      @(negedge clk);
      check_output("rst_line_ready", 32'(bus.line_ready), 32'd0);
      check_output("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check_output("rst_inst", bus.inst, NOOP_INST);
      check_output("rst_inst_pc", bus.inst_pc, 32'd0);
      check_output("rst_is_ctrl", 32'(bus.inst_is_ctrl), 32'd0);
      tick();
      @(negedge clk);
      check_output("rst2_line_ready", 32'(bus.line_ready), 32'd0);
      tick();
      rst            = 1'b0;
      bus.line_valid = 1'b0;
      @(negedge clk);
      check_output("post_rst_ready", 32'(bus.line_ready), 32'd1);

      // Full line at 0x100 followed back-to-back by 0x120
      tick();
      apply_stimulus(1, 32'h100, 0, 8'h00);
      push_expected(1, 32'h100, 0, 7, 8'h00);
      @(negedge clk);
      check_output("full_accept_ready", 32'(bus.line_ready), 32'd1);
      tick();
      bus.line_valid = 1'b0;
      @(negedge clk);
      check_output("first_latency", 32'(bus.inst_valid), 32'd1);
      check_output("mid_line_ready_low", 32'(bus.line_ready), 32'd0);
      repeat (7) tick();
      apply_stimulus(2, 32'h120, 0, 8'h00);
      push_expected(2, 32'h120, 0, 7, 8'h00);
      @(negedge clk);
      check_output("last_fire_ready", 32'(bus.line_ready), 32'd1);
      tick();
      bus.line_valid = 1'b0;
      @(negedge clk);
      check_output("no_bubble_valid", 32'(bus.inst_valid), 32'd1);
      check_output("no_bubble_pc", bus.inst_pc, 32'h120);
      repeat (8) tick();
      @(negedge clk);
      check_output("line_end_empty", 32'(bus.inst_valid), 32'd0);

      // Mid-line entry at word 5 with unaligned line_pc and backpressure
      apply_stimulus(3, 32'h204, 5, 8'h00);
      push_expected(3, 32'h200, 5, 7, 8'h00);
      tick();
      bus.line_valid = 1'b0;
      bus.inst_ready = 1'b0;
      @(negedge clk);
      check_output("stall_w5_inst", bus.inst, make_word(3, 5, 1'b0));
      check_output("stall_w5_pc", bus.inst_pc, 32'h214);
      tick();
      bus.inst_ready = 1'b1;
      @(negedge clk);
      check_output("stall_hold_inst", bus.inst, make_word(3, 5, 1'b0));
      check_output("stall_hold_pc", bus.inst_pc, 32'h214);
      tick();
      bus.inst_ready = 1'b0;
      @(negedge clk);
      check_output("stall_w6_inst", bus.inst, make_word(3, 6, 1'b0));
      check_output("stall_w6_pc", bus.inst_pc, 32'h218);
      tick();
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      @(negedge clk);
      check_output("stall_w7_inst", bus.inst, make_word(3, 7, 1'b0));
      check_output("stall_w7_pc", bus.inst_pc, 32'h21C);
      tick();
      bus.inst_ready = 1'b1;
      tick();
      @(negedge clk);
      check_output("midline_end_empty", 32'(bus.inst_valid), 32'd0);

      // JAL at word 2 ends the line early
      apply_stimulus(4, 32'h300, 0, 8'h04);
      push_expected(4, 32'h300, 0, 2, 8'h04);
      tick();
      bus.line_valid = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check_output("ctrl_is_ctrl", 32'(bus.inst_is_ctrl), 32'd1);
      check_output("ctrl_fire_ready", 32'(bus.line_ready), 32'd0);
      tick();
      @(negedge clk);
      check_output("ctrl_after_valid", 32'(bus.inst_valid), 32'd0);
      check_output("ctrl_after_ready", 32'(bus.line_ready), 32'd1);

      // Flush at word 3 while the next line is already offered
      apply_stimulus(5, 32'h400, 0, 8'h00);
      push_expected(5, 32'h400, 0, 3, 8'h00);
      tick();
      bus.line_valid = 1'b0;
      repeat (3) tick();
      flush = 1'b1;
      apply_stimulus(6, 32'h500, 6, 8'h00);
      @(negedge clk);
      check_output("flush_blocks_line", 32'(bus.line_ready), 32'd0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      check_output("flush_inst_valid", 32'(bus.inst_valid), 32'd0);
      check_output("flush_inst", bus.inst, NOOP_INST);
      check_output("flush_then_ready", 32'(bus.line_ready), 32'd1);
      push_expected(6, 32'h500, 6, 7, 8'h00);
      tick();
      bus.line_valid = 1'b0;
      @(negedge clk);
      check_output("after_flush_pc", bus.inst_pc, 32'h518);
      tick();
      tick();
      @(negedge clk);
      check_output("after_flush_empty", 32'(bus.inst_valid), 32'd0);

      // Reset while word 4 of a line is presented
      apply_stimulus(7, 32'h600, 0, 8'h00);
      push_expected(7, 32'h600, 0, 3, 8'h00);
      tick();
      bus.line_valid = 1'b0;
      repeat (4) tick();
      rst            = 1'b1;
      bus.inst_ready = 1'b0;
      @(negedge clk);
      check_output("pre_reset_pc", bus.inst_pc, 32'h610);
      check_output("in_reset_ready", 32'(bus.line_ready), 32'd0);
      tick();
      rst            = 1'b0;
      bus.inst_ready = 1'b1;
      @(negedge clk);
      check_output("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check_output("midrst_inst", bus.inst, NOOP_INST);
      check_output("midrst_inst_pc", bus.inst_pc, 32'd0);
      check_output("midrst_is_ctrl", 32'(bus.inst_is_ctrl), 32'd0);
      check_output("midrst_ready", 32'(bus.line_ready), 32'd1);
      repeat (4) tick();
      @(negedge clk);
      check_output("midrst_stays_empty", 32'(bus.inst_valid), 32'd0);

      check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
      $finish;
   end

endmodule
